// File: rtl/s_axilite_ctrl_regs_if.sv
// AXI4-Lite bus bundle for the control/argument register file.
// The master drives addresses, data and the response ready strobes; the slave drives the rest.
interface s_axilite_ctrl_regs_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/s_axilite_ctrl_regs.sv
// AXI4-Lite slave exposing ap_ctrl handshake, GIE/IER/ISR interrupt logic and
// NUM_ARGS byte-maskable 32-bit argument registers with per-argument write pulses.
module s_axilite_ctrl_regs #(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_ARGS           = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    s_axilite_ctrl_regs_if.slave     s_axi,
    output logic                     ap_start,
    input  logic                     ap_done,
    input  logic                     ap_idle,
    input  logic                     ap_ready,
    output logic                     interrupt,
    output logic [NUM_ARGS*32-1:0]   args,
    output logic [NUM_ARGS-1:0]      arg_wr_pulse
);
    localparam int IDX_W   = C_S_AXI_ADDR_WIDTH - 2;
    localparam int STRB_W  = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    function automatic logic idx_mapped(input logic [IDX_W-1:0] idx);
        return 32'(idx) < 32'(4 + NUM_ARGS);
    endfunction

    // write channel state
    w_state_t                    w_state_reg, w_state_next;
    logic                        awready_reg, awready_next;
    logic                        wready_reg, wready_next;
    logic                        aw_held_reg, aw_held_next;
    logic                        w_held_reg, w_held_next;
    logic [IDX_W-1:0]            awidx_reg, awidx_next;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [STRB_W-1:0]           wstrb_reg, wstrb_next;
    logic                        bvalid_reg, bvalid_next;
    logic [1:0]                  bresp_reg, bresp_next;

    // read channel state
    r_state_t                    r_state_reg, r_state_next;
    logic                        arready_reg, arready_next;
    logic                        rvalid_reg, rvalid_next;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic [1:0]                  rresp_reg, rresp_next;

    // control registers
    logic       ap_start_reg, ap_start_next;
    logic       auto_restart_reg, auto_restart_next;
    logic       done_status_reg, done_status_next;
    logic       gie_reg, gie_next;
    logic [1:0] ier_reg, ier_next;
    logic [1:0] isr_reg, isr_next;
    logic       interrupt_reg;

    logic                          aw_hs, w_hs, ar_hs;
    logic                          wr_en;
    logic [IDX_W-1:0]              wr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]             wr_strb;
    logic [IDX_W-1:0]              rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
    logic                          ctrl_byte0_wr;

    wire unused_addr_lsbs = &{1'b0, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

    assign aw_hs  = s_axi.AWVALID && awready_reg;
    assign w_hs   = s_axi.WVALID && wready_reg;
    assign ar_hs  = s_axi.ARVALID && arready_reg;
    assign rd_idx = s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    assign s_axi.AWREADY = awready_reg;
    assign s_axi.WREADY  = wready_reg;
    assign s_axi.BVALID  = bvalid_reg;
    assign s_axi.BRESP   = bresp_reg;
    assign s_axi.ARREADY = arready_reg;
    assign s_axi.RVALID  = rvalid_reg;
    assign s_axi.RDATA   = rdata_reg;
    assign s_axi.RRESP   = rresp_reg;
    assign ap_start      = ap_start_reg;
    assign interrupt     = interrupt_reg;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_reg      <= W_IDLE;
            awready_reg      <= 1'b0;
            wready_reg       <= 1'b0;
            aw_held_reg      <= 1'b0;
            w_held_reg       <= 1'b0;
            awidx_reg        <= '0;
            wdata_reg        <= '0;
            wstrb_reg        <= '0;
            bvalid_reg       <= 1'b0;
            bresp_reg        <= RESP_OKAY;
            r_state_reg      <= R_IDLE;
            arready_reg      <= 1'b0;
            rvalid_reg       <= 1'b0;
            rdata_reg        <= '0;
            rresp_reg        <= RESP_OKAY;
            ap_start_reg     <= 1'b0;
            auto_restart_reg <= 1'b0;
            done_status_reg  <= 1'b0;
            gie_reg          <= 1'b0;
            ier_reg          <= 2'b00;
            isr_reg          <= 2'b00;
            interrupt_reg    <= 1'b0;
        end else begin
            w_state_reg      <= w_state_next;
            awready_reg      <= awready_next;
            wready_reg       <= wready_next;
            aw_held_reg      <= aw_held_next;
            w_held_reg       <= w_held_next;
            awidx_reg        <= awidx_next;
            wdata_reg        <= wdata_next;
            wstrb_reg        <= wstrb_next;
            bvalid_reg       <= bvalid_next;
            bresp_reg        <= bresp_next;
            r_state_reg      <= r_state_next;
            arready_reg      <= arready_next;
            rvalid_reg       <= rvalid_next;
            rdata_reg        <= rdata_next;
            rresp_reg        <= rresp_next;
            ap_start_reg     <= ap_start_next;
            auto_restart_reg <= auto_restart_next;
            done_status_reg  <= done_status_next;
            gie_reg          <= gie_next;
            ier_reg          <= ier_next;
            isr_reg          <= isr_next;
            interrupt_reg    <= gie_reg & (isr_reg[0] | isr_reg[1]);
        end
    end

    // A channel accepted this cycle is used directly, so AW and W may meet in one cycle.
    always_comb begin
        w_state_next = w_state_reg;
        awready_next = awready_reg;
        wready_next  = wready_reg;
        aw_held_next = aw_held_reg;
        w_held_next  = w_held_reg;
        awidx_next   = awidx_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        bvalid_next  = bvalid_reg;
        bresp_next   = bresp_reg;
        wr_en        = 1'b0;
        wr_idx       = aw_hs ? s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : awidx_reg;
        wr_data      = w_hs ? s_axi.WDATA : wdata_reg;
        wr_strb      = w_hs ? s_axi.WSTRB : wstrb_reg;
        case (w_state_reg)
            W_IDLE: begin
                if ((aw_held_reg || aw_hs) && (w_held_reg || w_hs)) begin
                    wr_en        = 1'b1;
                    w_state_next = W_RESP;
                    bvalid_next  = 1'b1;
                    bresp_next   = idx_mapped(wr_idx) ? RESP_OKAY : RESP_SLVERR;
                    aw_held_next = 1'b0;
                    w_held_next  = 1'b0;
                    awready_next = 1'b0;
                    wready_next  = 1'b0;
                end else begin
                    if (aw_hs) begin
                        aw_held_next = 1'b1;
                        awidx_next   = wr_idx;
                        awready_next = 1'b0;
                    end else if (!aw_held_reg) begin
                        awready_next = 1'b1;
                    end
                    if (w_hs) begin
                        w_held_next = 1'b1;
                        wdata_next  = wr_data;
                        wstrb_next  = wr_strb;
                        wready_next = 1'b0;
                    end else if (!w_held_reg) begin
                        wready_next = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (s_axi.BREADY) begin
                    w_state_next = W_IDLE;
                    bvalid_next  = 1'b0;
                    bresp_next   = RESP_OKAY;
                    awready_next = 1'b1;
                    wready_next  = 1'b1;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Live done event is ORed in so a read racing the done pulse still reports it.
    always_comb begin
        rd_word = '0;
        case (32'(rd_idx))
            32'd0:   rd_word[7:0] = {auto_restart_reg, 3'b000, ap_ready, ap_idle,
                                     done_status_reg | ap_done, ap_start_reg};
            32'd1:   rd_word[0]   = gie_reg;
            32'd2:   rd_word[1:0] = ier_reg;
            32'd3:   rd_word[1:0] = isr_reg;
            default: begin
                for (int i = 0; i < NUM_ARGS; i++) begin
                    if (32'(rd_idx) == 32'(4 + i)) rd_word = args[32*i +: 32];
                end
            end
        endcase
    end

    always_comb begin
        r_state_next = r_state_reg;
        arready_next = arready_reg;
        rvalid_next  = rvalid_reg;
        rdata_next   = rdata_reg;
        rresp_next   = rresp_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_next = R_DATA;
                    arready_next = 1'b0;
                    rvalid_next  = 1'b1;
                    rdata_next   = rd_word;
                    rresp_next   = idx_mapped(rd_idx) ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    arready_next = 1'b1;
                end
            end
            R_DATA: begin
                if (s_axi.RREADY) begin
                    r_state_next = R_IDLE;
                    arready_next = 1'b1;
                    rvalid_next  = 1'b0;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // Control register updates; event-driven sets take priority over bus writes/clears.
    always_comb begin
        ctrl_byte0_wr     = wr_en && wr_strb[0];
        ap_start_next     = ap_start_reg;
        auto_restart_next = auto_restart_reg;
        done_status_next  = done_status_reg;
        gie_next          = gie_reg;
        ier_next          = ier_reg;
        isr_next          = isr_reg;
        if (ctrl_byte0_wr && 32'(wr_idx) == 32'd0) begin
            auto_restart_next = wr_data[7];
        end
        if (ctrl_byte0_wr && 32'(wr_idx) == 32'd0 && wr_data[0]) begin
            ap_start_next = 1'b1;
        end else if (ap_ready && !auto_restart_reg) begin
            ap_start_next = 1'b0;
        end
        if (ap_done) begin
            done_status_next = 1'b1;
        end else if (ar_hs && 32'(rd_idx) == 32'd0) begin
            done_status_next = 1'b0;
        end
        if (ctrl_byte0_wr && 32'(wr_idx) == 32'd1) gie_next = wr_data[0];
        if (ctrl_byte0_wr && 32'(wr_idx) == 32'd2) ier_next = wr_data[1:0];
        for (int k = 0; k < 2; k++) begin
            if (ier_reg[k] && (k == 0 ? ap_done : ap_ready)) begin
                isr_next[k] = 1'b1;
            end else if (ctrl_byte0_wr && 32'(wr_idx) == 32'd3 && wr_data[k]) begin
                isr_next[k] = ~isr_reg[k];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_ARGS; gi++) begin : g_arg
            logic        hit;
            logic [31:0] arg_reg;
            logic        pulse_reg;

            assign hit = wr_en && (32'(wr_idx) == 32'(4 + gi));

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    arg_reg   <= '0;
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= hit;
                    for (int b = 0; b < 4; b++) begin
                        if (hit && wr_strb[b]) arg_reg[8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end

            assign args[32*gi +: 32] = arg_reg;
            assign arg_wr_pulse[gi]  = pulse_reg;
        end
    endgenerate
endmodule

// File: tb/tb_s_axilite_ctrl_regs.sv
// Directed plus randomized bench for s_axilite_ctrl_regs, checked against a
// register-level reference model of the control block and argument file.
module tb_s_axilite_ctrl_regs;
    localparam int AW = 7;
    localparam int NA = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    s_axilite_ctrl_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    logic             ap_start;
    logic             ap_done = 1'b0;
    logic             ap_idle = 1'b0;
    logic             ap_ready = 1'b0;
    logic             interrupt;
    logic [NA*32-1:0] args;
    logic [NA-1:0]    arg_wr_pulse;

    s_axilite_ctrl_regs #(
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_S_AXI_DATA_WIDTH(32),
        .NUM_ARGS(NA)
    ) dut (
        .ACLK(clk),
        .ARESETN(rst_n),
        .s_axi(bus),
        .ap_start(ap_start),
        .ap_done(ap_done),
        .ap_idle(ap_idle),
        .ap_ready(ap_ready),
        .interrupt(interrupt),
        .args(args),
        .arg_wr_pulse(arg_wr_pulse)
    );

    // reference model state
    bit          m_start, m_auto, m_done, m_gie;
    bit [1:0]    m_ier, m_isr;
    logic [31:0] m_arg [NA];

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_mapped(input int addr);
        return (addr >> 2) < 4 + NA;
    endfunction

    function automatic logic [127:0] model_args();
        logic [127:0] v = '0;
        for (int i = 0; i < NA; i++) v[32*i +: 32] = m_arg[i];
        return v;
    endfunction

    task automatic model_reset();
        m_start = 0; m_auto = 0; m_done = 0; m_gie = 0; m_ier = 0; m_isr = 0;
        for (int i = 0; i < NA; i++) m_arg[i] = 32'h0;
    endtask

    task automatic model_write(input int addr, input logic [31:0] d, input logic [3:0] s);
        int idx = addr >> 2;
        if (idx == 0 && s[0]) begin
            if (d[0]) m_start = 1;
            m_auto = d[7];
        end else if (idx == 1 && s[0]) m_gie = d[0];
        else if (idx == 2 && s[0]) m_ier = d[1:0];
        else if (idx == 3 && s[0]) m_isr = m_isr ^ d[1:0];
        else if (idx >= 4 && idx < 4 + NA) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_arg[idx-4][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic model_read(input int addr, output logic [31:0] d, output logic [1:0] r);
        int idx = addr >> 2;
        d = 32'h0;
        r = is_mapped(addr) ? 2'b00 : 2'b10;
        if (idx == 0) begin
            d = {24'h0, m_auto, 3'b000, 1'b0, ap_idle, m_done, m_start};
            m_done = 0;
        end else if (idx == 1) d = {31'h0, m_gie};
        else if (idx == 2) d = {30'h0, m_ier};
        else if (idx == 3) d = {30'h0, m_isr};
        else if (idx < 4 + NA) d = m_arg[idx-4];
    endtask

    task automatic axi_write(input int addr, input logic [31:0] d, input logic [3:0] s,
                             input int awd, input int wd);
        bit aw_done = 0, w_done = 0, af, wf;
        int cyc = 0;
        logic [NA-1:0] exp_pulse = '0;
        logic [1:0] exp_resp = is_mapped(addr) ? 2'b00 : 2'b10;
        if (is_mapped(addr) && (addr >> 2) >= 4) exp_pulse[(addr >> 2) - 4] = 1'b1;
        bus.BREADY = 1'b1;
        bus.AWADDR = AW'(addr);
        bus.WDATA  = d;
        bus.WSTRB  = s;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clk);
            bus.AWVALID = !aw_done && cyc >= awd;
            bus.WVALID  = !w_done && cyc >= wd;
            af = bus.AWVALID && bus.AWREADY;
            wf = bus.WVALID && bus.WREADY;
            @(posedge clk);
            if (af) aw_done = 1;
            if (wf) w_done = 1;
            cyc++;
        end
        @(negedge clk);
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        check_val("wr_accept", aw_done && w_done, 1);
        cyc = 0;
        while (!bus.BVALID && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        model_write(addr, d, s);
        check_val("wr_bvalid", bus.BVALID, 1);
        check_val("wr_bresp", bus.BRESP, exp_resp);
        check_val("wr_pulse", arg_wr_pulse, exp_pulse);
        check_val("wr_args", args, model_args());
        $display("write addr=%02h data=%08h strb=%b resp=%b pulse=%b", addr, d, s, bus.BRESP, arg_wr_pulse);
        @(negedge clk);
        check_val("wr_bdone", bus.BVALID, 0);
        check_val("wr_pulse_end", arg_wr_pulse, 0);
    endtask

    task automatic axi_read(input int addr, input int hold);
        int cyc = 0;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        @(negedge clk);
        bus.ARADDR  = AW'(addr);
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b0;
        while (!bus.ARREADY && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_val("rd_arready", bus.ARREADY, 1);
        model_read(addr, exp_d, exp_r);
        @(negedge clk);
        bus.ARVALID = 1'b0;
        cyc = 0;
        while (!bus.RVALID && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_val("rd_rvalid", bus.RVALID, 1);
        check_val("rd_data", bus.RDATA, exp_d);
        check_val("rd_resp", bus.RRESP, exp_r);
        $display("read  addr=%02h data=%08h resp=%b hold=%0d", addr, bus.RDATA, bus.RRESP, hold);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val("rd_hold_valid", bus.RVALID, 1);
            check_val("rd_hold_data", bus.RDATA, exp_d);
        end
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;
        check_val("rd_rdone", bus.RVALID, 0);
    endtask

    task automatic core_pulse(input bit d, input bit r);
        @(negedge clk);
        ap_done  = d;
        ap_ready = r;
        @(negedge clk);
        ap_done  = 1'b0;
        ap_ready = 1'b0;
        if (r && !m_auto) m_start = 0;
        if (d) m_done = 1;
        if (d && m_ier[0]) m_isr[0] = 1;
        if (r && m_ier[1]) m_isr[1] = 1;
        check_val("core_ap_start", ap_start, m_start);
        $display("core  done=%0d ready=%0d ap_start=%0d", d, r, ap_start);
    endtask

    task automatic check_outputs();
        @(negedge clk);
        @(negedge clk);
        check_val("out_interrupt", interrupt, m_gie & (m_isr[0] | m_isr[1]));
        check_val("out_ap_start", ap_start, m_start);
        check_val("out_args", args, model_args());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.AWADDR = '0; bus.AWVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0;
        bus.BREADY = 0; bus.ARADDR = '0; bus.ARVALID = 0; bus.RREADY = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_awready", bus.AWREADY, 0);
        check_val("rst_arready", bus.ARREADY, 0);
        check_val("rst_bvalid", bus.BVALID, 0);
        check_val("rst_rvalid", bus.RVALID, 0);
        check_val("rst_rdata", bus.RDATA, 0);
        check_val("rst_ap_start", ap_start, 0);
        check_val("rst_interrupt", interrupt, 0);
        check_val("rst_args", args, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_awready", bus.AWREADY, 1);
        check_val("post_rst_wready", bus.WREADY, 1);
        check_val("post_rst_arready", bus.ARREADY, 1);

        // argument write with AW ahead of W, then readback
        axi_write(32'h14, 32'hDEADBEEF, 4'b1111, 0, 2);
        check_val("arg1_value", args[63:32], 32'hDEADBEEF);
        axi_read(32'h14, 0);

        // byte-masked write and unmapped accesses
        axi_write(32'h10, 32'h11223344, 4'b1111, 0, 0);
        axi_write(32'h10, 32'hAABBCCDD, 4'b0101, 1, 0);
        check_val("arg0_partial", args[31:0], 32'h11BB33DD);
        axi_read(32'h40, 0);
        axi_write(32'h40, 32'h12345678, 4'b1111, 0, 0);
        axi_write(32'h18, 32'h0BAD0BAD, 4'b0000, 0, 1);

        // start/done/ready handshake with clear-on-read done status
        ap_idle = 1'b1;
        axi_write(32'h00, 32'h01, 4'b0001, 0, 0);
        check_outputs();
        core_pulse(1, 1);
        axi_read(32'h00, 0);
        axi_read(32'h00, 0);

        // auto-restart keeps ap_start up across ready pulses
        axi_write(32'h00, 32'h81, 4'b0001, 0, 0);
        repeat (3) core_pulse(0, 1);
        axi_write(32'h00, 32'h00, 4'b0001, 0, 0);
        core_pulse(0, 1);

        // interrupt path
        axi_write(32'h04, 32'h1, 4'b0001, 0, 0);
        axi_write(32'h08, 32'h1, 4'b0001, 0, 0);
        core_pulse(1, 0);
        @(negedge clk);
        check_val("irq_raise", interrupt, 1);
        axi_write(32'h0C, 32'h1, 4'b0001, 0, 0);
        check_outputs();
        axi_write(32'h08, 32'h0, 4'b0001, 0, 0);
        core_pulse(1, 0);
        check_outputs();

        // read data held while RREADY is low
        axi_read(32'h14, 5);

        // reset while AW is accepted and W is still outstanding
        @(negedge clk);
        bus.AWADDR = AW'(32'h10);
        bus.AWVALID = 1'b1;
        @(negedge clk);
        bus.AWVALID = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_val("midrst_awready", bus.AWREADY, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("midrst_bvalid", bus.BVALID, 0);
        end
        check_val("midrst_args", args, model_args());

        // randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            int op = $urandom_range(0, 3);
            int addr = $urandom_range(0, 31) * 4;
            if (op == 0) axi_write(addr, $urandom, 4'($urandom_range(0, 15)),
                                   $urandom_range(0, 3), $urandom_range(0, 3));
            else if (op == 1) axi_read($urandom_range(0, 1) == 0 ? addr : $urandom_range(0, 7) * 4,
                                       $urandom_range(0, 3));
            else if (op == 2) begin
                ap_idle = 1'($urandom_range(0, 1));
                core_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else check_outputs();
        end
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/s_axilite_ctrl_regs.md
Name: s_axilite_ctrl_regs

Overview:
Parametrised AXI4-Lite slave control/argument register file, successor to the single-argument control interface.
- Provides the HLS-style ap_ctrl block (start/done/idle/ready, auto-restart), GIE/IER/ISR with an interrupt output, and NUM_ARGS 32-bit argument registers, each with its own write pulse.
- Accepts AW and W in either order or together, and returns SLVERR for unmapped addresses.
- Sits between the PS GP port and the PL compute core.

Parameters:
C_S_AXI_ADDR_WIDTH, 6, byte address width; must satisfy 2^width >= 0x10 + 4*NUM_ARGS.
C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
NUM_ARGS, 4, number of argument registers (1..16).

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
AWVALID / AWREADY  in / out  1  write address handshake
WDATA  in  32  write data
WSTRB  in  4  byte strobes
WVALID / WREADY  in / out  1  write data handshake
BRESP  out  2  write response: 00 OKAY, 10 SLVERR
BVALID / BREADY  out / in  1  write response handshake
ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
ARVALID / ARREADY  in / out  1  read address handshake
RDATA  out  32  read data
RRESP  out  2  read response: 00 / 10
RVALID / RREADY  out / in  1  read data handshake
ap_start  out  1  start request to core
ap_done  in  1  core done pulse
ap_idle  in  1  core idle level
ap_ready  in  1  core ready pulse
interrupt  out  1  level interrupt
args  out  NUM_ARGS*32  argument i occupies bits [32*i+31:32*i]
arg_wr_pulse  out  NUM_ARGS  1-cycle pulse when argument i is written

Behaviour:
- Reset (ARESETN low, asynchronous): every output register clears.
  - AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; RDATA = 0; BRESP/RRESP = 00.
  - ap_start, interrupt, args, arg_wr_pulse = 0; all internal registers = 0.
  - AWREADY and ARREADY are first asserted on the first cycle after deassertion.
  - Reset mid-transaction abandons that transaction: no BVALID/RVALID, no register update.
- Address map, decoded on word-aligned address bits [ADDR_WIDTH-1:2]:
  - 0x00 CTRL: b0 ap_start (R/W, set-only), b1 ap_done (R, clear-on-read), b2 ap_idle (R, live), b3 ap_ready (R, live), b7 auto_restart (R/W).
  - 0x04 GIE: b0 global interrupt enable.
  - 0x08 IER: b0 done enable, b1 ready enable.
  - 0x0C ISR: b0 done status, b1 ready status; toggle-on-write.
  - 0x10+4*i ARG i: 32-bit R/W, byte-masked by WSTRB.
  - Any other offset is unmapped.
- Write channel: states W_IDLE, W_RESP.
  - In W_IDLE, AWREADY and WREADY stay high until their channel handshakes; each accepted channel is latched and its READY drops.
  - When both address and data are held (same cycle or different cycles), the register update happens that cycle and the FSM goes to W_RESP with BVALID=1.
  - BVALID and BRESP hold until BREADY; then return to W_IDLE, with AWREADY/WREADY high the next cycle.
  - Unmapped write: no register change, BRESP=10.
- arg_wr_pulse[i]: high for exactly the update cycle of a mapped write to ARG i, including WSTRB=0000. args change the same cycle (registered, visible next edge).
- Read channel: states R_IDLE, R_DATA.
  - ARREADY=1 in R_IDLE. On AR handshake, RDATA/RRESP are registered and the FSM goes to R_DATA with RVALID=1.
  - RDATA and RRESP are held stable until RREADY.
  - Unmapped read: RDATA=0, RRESP=10.
  - Read and write channels run concurrently. If a read and a write to the same register capture in the same cycle, the read returns the pre-write value.
- ap_start:
  - Set by a write to CTRL with WSTRB[0]=1 and WDATA[0]=1; writing 0 has no effect.
  - When ap_ready=1: cleared if auto_restart=0, held if auto_restart=1.
  - A set on the same cycle as ap_ready wins.
- ap_done status bit: set on ap_done=1; cleared on an AR handshake to CTRL. Set wins over a simultaneous clear, and the read returns 1.
- ISR[k]: set when IER[k] and its event (k=0 ap_done, k=1 ap_ready) are both 1. Otherwise toggled by a write with WDATA[k]=1 and WSTRB[0]=1. Set wins over toggle.
- interrupt = GIE & (ISR[0] | ISR[1]), registered, 1-cycle latency.

Test Plan:
- Reset then write ARG1=0xDEADBEEF with WSTRB=1111, AW two cycles before W -> BRESP=00; arg_wr_pulse=0010 for one cycle; args[63:32]=0xDEADBEEF; readback 0xDEADBEEF.
- Partial write to ARG0 (initially 0x11223344) of 0xAABBCCDD with WSTRB=0101 -> ARG0=0x11BB33DD; read of 0x40 (unmapped) -> RDATA=0, RRESP=10; write to 0x40 -> BRESP=10 and no pulse.
- Write CTRL=0x01, then pulse ap_ready and ap_done -> ap_start clears the cycle after ap_ready. First CTRL read: b1=1. Second CTRL read: b1=0.
- Write CTRL=0x81 (auto_restart), pulse ap_ready three times -> ap_start stays 1. Write CTRL=0x00, pulse ap_ready -> ap_start 0.
- GIE=1, IER=01, pulse ap_done -> interrupt=1 one cycle later. Write ISR=0x1 -> interrupt=0. Repeat with IER=00 -> interrupt stays 0.
- Hold RREADY=0 for 5 cycles during a read -> RVALID and RDATA stable. Assert ARESETN=0 mid-write with AW accepted and W pending -> BVALID=0 after reset and ARG unchanged.
